// File: rtl/tim5_etb_pkg.sv
// Shared constants for the tim5 event-trigger router: APB register offsets,
// CFG field layout and the fixed channel-to-destination assignment.
package tim5_etb_pkg;

  localparam logic [11:0] REG_EN       = 12'h000;
  localparam logic [11:0] REG_CFG_BASE = 12'h004;
  localparam logic [11:0] REG_SWTRIG   = 12'h040;
  localparam logic [11:0] REG_STATUS   = 12'h044;
  localparam logic [11:0] REG_INTEN    = 12'h048;

  localparam int CFG_SRC_LSB  = 0;
  localparam int CFG_SRC_W    = 5;
  localparam int CFG_EDGE_BIT = 8;

  localparam int TIM1_ON  = 0;
  localparam int TIM1_OFF = 1;
  localparam int TIM2_ON  = 2;
  localparam int TIM2_OFF = 3;

  // CFG_c lives at CFG_BASE + 4*c; slots that would reach SWTRIG are not decoded.
  function automatic logic [11:0] cfg_addr(input int c);
    return REG_CFG_BASE + 12'(4 * c);
  endfunction

endpackage

// File: rtl/tim5_etb_chan.sv
// One router channel: source select, edge qualify, SW-trigger merge,
// registered one-cycle destination pulse and sticky W1C status (set wins).
import tim5_etb_pkg::*;

module tim5_etb_chan #(
  parameter int NSRC = 8
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 i_en,
  input  logic [CFG_SRC_W-1:0] i_src_sel,
  input  logic                 i_edge,
  input  logic [NSRC-1:0]      i_src_trig,
  input  logic [NSRC-1:0]      i_src_q,
  input  logic                 i_sw,
  input  logic                 i_clr,
  output logic                 o_dst,
  output logic                 o_status
);

  logic w_cur;
  logic w_prev;
  logic w_hit;
  logic w_fire;
  logic r_dst;
  logic r_status;

  // Out-of-range selects leave both samples at 0, so no edge can appear.
  always_comb begin
    w_cur  = 1'b0;
    w_prev = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (i_src_sel == s[CFG_SRC_W-1:0]) begin
        w_cur  = i_src_trig[s];
        w_prev = i_src_q[s];
      end
    end
  end

  assign w_hit  = i_en & (i_edge ? (w_prev & ~w_cur) : (~w_prev & w_cur));
  assign w_fire = w_hit | (i_sw & i_en);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_dst    <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_dst    <= w_fire;
      r_status <= w_fire | (r_status & ~i_clr);
    end
  end

  assign o_dst    = r_dst;
  assign o_status = r_status;

endmodule

// File: rtl/tim5_etb_router.sv
// Event-trigger router top: APB decode, EN/CFG/INTEN registers, source
// history register, read mux and registered interrupt around NCH channels.
import tim5_etb_pkg::*;

module tim5_etb_router #(
  parameter int NSRC = 8,
  parameter int NCH  = 4
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [11:0]     paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  input  logic [NSRC-1:0] src_trig,
  output logic [NCH-1:0]  dst_trig,
  output logic            intr
);

  logic [11:0]          w_addr;
  logic                 w_wr;
  logic                 w_rd;
  logic [NCH-1:0]       w_sw_mask;
  logic [NCH-1:0]       w_clr_mask;
  logic [NCH-1:0]       w_status;
  logic                 w_unused;

  logic [NCH-1:0]       r_en;
  logic [NCH-1:0]       r_inten;
  logic [CFG_SRC_W-1:0] r_cfg_src [NCH];
  logic [NCH-1:0]       r_cfg_edge;
  logic [NSRC-1:0]      r_src_q;
  logic                 r_intr;

  assign w_addr   = {paddr[11:2], 2'b00};
  assign w_wr     = psel & penable & pwrite;
  assign w_rd     = psel & ~pwrite;
  assign w_unused = ^{paddr[1:0], pwdata};

  assign w_sw_mask  = (w_wr && w_addr == REG_SWTRIG) ? pwdata[NCH-1:0] : '0;
  assign w_clr_mask = (w_wr && w_addr == REG_STATUS) ? pwdata[NCH-1:0] : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_en       <= '0;
      r_inten    <= '0;
      r_cfg_edge <= '0;
      for (int c = 0; c < NCH; c++) r_cfg_src[c] <= '0;
    end else if (w_wr) begin
      if (w_addr == REG_EN)    r_en    <= pwdata[NCH-1:0];
      if (w_addr == REG_INTEN) r_inten <= pwdata[NCH-1:0];
      for (int c = 0; c < NCH; c++) begin
        if (w_addr == cfg_addr(c) && cfg_addr(c) < REG_SWTRIG) begin
          r_cfg_src[c]  <= pwdata[CFG_SRC_LSB +: CFG_SRC_W];
          r_cfg_edge[c] <= pwdata[CFG_EDGE_BIT];
        end
      end
    end
  end

  // Loads through reset so a level present at release is not seen as an edge.
  always_ff @(posedge pclk) begin
    r_src_q <= src_trig;
  end

  always_ff @(posedge pclk) begin
    if (preset) r_intr <= 1'b0;
    else        r_intr <= |(w_status & r_inten);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    tim5_etb_chan #(.NSRC(NSRC)) u_chan (
      .pclk       (pclk),
      .preset     (preset),
      .i_en       (r_en[g]),
      .i_src_sel  (r_cfg_src[g]),
      .i_edge     (r_cfg_edge[g]),
      .i_src_trig (src_trig),
      .i_src_q    (r_src_q),
      .i_sw       (w_sw_mask[g]),
      .i_clr      (w_clr_mask[g]),
      .o_dst      (dst_trig[g]),
      .o_status   (w_status[g])
    );
  end

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      if (w_addr == REG_EN)     prdata[NCH-1:0] = r_en;
      if (w_addr == REG_STATUS) prdata[NCH-1:0] = w_status;
      if (w_addr == REG_INTEN)  prdata[NCH-1:0] = r_inten;
      for (int c = 0; c < NCH; c++) begin
        if (w_addr == cfg_addr(c) && cfg_addr(c) < REG_SWTRIG) begin
          prdata[CFG_SRC_LSB +: CFG_SRC_W] = r_cfg_src[c];
          prdata[CFG_EDGE_BIT]             = r_cfg_edge[c];
        end
      end
    end
  end

  assign intr = r_intr;

endmodule

// File: tb/tb_tim5_etb_router.sv
// Directed bench for tim5_etb_router: edge routing, SW triggers, status/W1C,
// interrupt timing, register map and reset behaviour.
module tb_tim5_etb_router;
  import tim5_etb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [7:0]  src_trig;
  logic [3:0]  dst_trig;
  logic        intr;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt [4];
  int cnt0_before;
  logic [31:0] rd;

  tim5_etb_router #(.NSRC(8), .NCH(4)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .src_trig (src_trig),
    .dst_trig (dst_trig),
    .intr     (intr)
  );

  always #5 pclk = ~pclk;

  initial for (int c = 0; c < 4; c++) cnt[c] = 0;
  always @(negedge pclk) begin
    for (int c = 0; c < 4; c++) cnt[c] = cnt[c] + int'(dst_trig[c]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_setup(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
  endtask

  task automatic apb_commit();
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    apb_setup(a, d);
    apb_commit();
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
    #1;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; src_trig = 8'h01;
    repeat (3) tick();
    chk("rst_dst", {28'b0, dst_trig}, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    chk("rst_prdata_idle", prdata, 32'h0);
    preset = 1'b0;
    tick();

    // ch0: src0 rising; src0 already high at release
    apb_wr(cfg_addr(TIM1_ON), 32'h000);
    apb_wr(REG_EN, 32'h1);
    repeat (3) tick();
    chk("held_high_no_pulse", cnt[0], 0);
    src_trig[0] = 1'b0;
    repeat (2) tick();
    src_trig[0] = 1'b1;
    #1;
    chk("rise_pre_edge", {28'b0, dst_trig}, 32'h0);
    tick();
    chk("rise_pulse", {28'b0, dst_trig}, 32'h1);
    tick();
    chk("rise_width", {28'b0, dst_trig}, 32'h0);
    apb_rd(REG_STATUS, rd);
    chk("rise_status", rd, 32'h1);
    chk("rise_count", cnt[0], 1);

    // ch1: src1 falling
    apb_wr(REG_STATUS, 32'hF);
    apb_wr(cfg_addr(TIM1_OFF), 32'h101);
    apb_wr(REG_EN, 32'h3);
    src_trig[1] = 1'b1;
    repeat (5) tick();
    chk("fall_no_rise_pulse", cnt[1], 0);
    src_trig[1] = 1'b0;
    tick();
    chk("fall_pulse", {28'b0, dst_trig}, 32'h2);
    tick();
    chk("fall_width", {28'b0, dst_trig}, 32'h0);
    chk("fall_count", cnt[1], 1);

    // SWTRIG with EN = 0x5; ch2 cfg defaults to src0 rising
    apb_wr(REG_STATUS, 32'hF);
    apb_wr(REG_EN, 32'h5);
    apb_wr(REG_SWTRIG, 32'hF);
    chk("sw_pulse", {28'b0, dst_trig}, 32'h5);
    tick();
    chk("sw_width", {28'b0, dst_trig}, 32'h0);
    apb_rd(REG_STATUS, rd);
    chk("sw_status", rd, 32'h5);
    apb_rd(REG_SWTRIG, rd);
    chk("swtrig_reads_0", rd, 32'h0);

    // SWTRIG coinciding with hardware rising edge on src0
    apb_wr(REG_STATUS, 32'hF);
    src_trig[0] = 1'b0;
    tick();
    cnt0_before = cnt[0];
    apb_setup(REG_SWTRIG, 32'h1);
    src_trig[0] = 1'b1;
    apb_commit();
    chk("sw_hw_pulse", {28'b0, dst_trig}, 32'h5);
    tick();
    chk("sw_hw_width", {28'b0, dst_trig}, 32'h0);
    chk("sw_hw_single", cnt[0] - cnt0_before, 1);
    apb_rd(REG_STATUS, rd);
    chk("sw_hw_status", rd, 32'h5);

    // interrupt timing and set-wins W1C
    apb_wr(REG_STATUS, 32'hF);
    apb_wr(REG_INTEN, 32'h1);
    tick();
    chk("intr_idle", {31'b0, intr}, 32'h0);
    src_trig[0] = 1'b0;
    tick();
    src_trig[0] = 1'b1;
    tick();
    chk("intr_lag", {31'b0, intr}, 32'h0);
    tick();
    chk("intr_set", {31'b0, intr}, 32'h1);
    src_trig[0] = 1'b0;
    tick();
    apb_setup(REG_STATUS, 32'h1);
    src_trig[0] = 1'b1;
    apb_commit();
    apb_rd(REG_STATUS, rd);
    chk("w1c_set_wins", rd, 32'h5);
    tick();
    chk("w1c_set_wins_intr", {31'b0, intr}, 32'h1);
    apb_wr(REG_STATUS, 32'h1);
    apb_rd(REG_STATUS, rd);
    chk("w1c_clear", rd, 32'h4);
    tick();
    chk("w1c_intr_low", {31'b0, intr}, 32'h0);

    // disable write on the same edge as a hardware edge: old EN still fires
    src_trig[0] = 1'b0;
    tick();
    apb_setup(REG_EN, 32'h0);
    src_trig[0] = 1'b1;
    apb_commit();
    chk("disable_same_edge", {28'b0, dst_trig}, 32'h5);
    src_trig[0] = 1'b0;
    tick();
    src_trig[0] = 1'b1;
    tick();
    chk("disabled_no_pulse", {28'b0, dst_trig}, 32'h0);

    // register map
    apb_wr(cfg_addr(TIM1_ON), 32'h103);
    apb_rd(12'h004, rd);
    chk("cfg0_readback", rd, 32'h103);
    apb_rd(12'h0F0, rd);
    chk("unmapped_read", rd, 32'h0);
    apb_wr(REG_EN, 32'h5);
    apb_wr(12'h0F0, 32'hFFFF_FFFF);
    apb_rd(REG_EN, rd);
    chk("unmapped_wr_en", rd, 32'h5);
    apb_rd(REG_INTEN, rd);
    chk("unmapped_wr_inten", rd, 32'h1);
    apb_rd(12'h004, rd);
    chk("unmapped_wr_cfg0", rd, 32'h103);

    // src_sel = 9 (out of range) never fires
    apb_wr(cfg_addr(TIM1_ON), 32'h009);
    cnt0_before = cnt[0];
    src_trig = 8'h00;
    tick();
    src_trig = 8'hFF;
    tick();
    src_trig = 8'h00;
    repeat (2) tick();
    chk("src_oor_no_fire", cnt[0] - cnt0_before, 0);

    // reset mid-operation with dst_trig[2] high and STATUS = 0xF
    apb_wr(REG_EN, 32'hF);
    apb_wr(REG_SWTRIG, 32'hF);
    chk("pre_rst_dst", {28'b0, dst_trig}, 32'hF);
    apb_rd(REG_STATUS, rd);
    chk("pre_rst_status", rd, 32'hF);
    preset = 1'b1;
    tick();
    chk("mid_rst_dst", {28'b0, dst_trig}, 32'h0);
    chk("mid_rst_intr", {31'b0, intr}, 32'h0);
    apb_rd(REG_STATUS, rd);
    chk("mid_rst_status", rd, 32'h0);
    apb_rd(REG_EN, rd);
    chk("mid_rst_en", rd, 32'h0);
    preset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
